// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 constants, FSM states and the game key table.
// Imported by the key tracker and the key lookup.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_OVR_LO = 8'h00;
  localparam logic [7:0] PS2_OVR_HI = 8'hFF;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

  localparam int KEY_COUNT = 10;

  localparam int KEY_W     = 0;
  localparam int KEY_S     = 1;
  localparam int KEY_A     = 2;
  localparam int KEY_D     = 3;
  localparam int KEY_UP    = 4;
  localparam int KEY_DOWN  = 5;
  localparam int KEY_LEFT  = 6;
  localparam int KEY_RIGHT = 7;
  localparam int KEY_SPACE = 8;
  localparam int KEY_ESC   = 9;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
  } key_ent_t;

  localparam key_ent_t KEY_TABLE [KEY_COUNT] = '{
    '{code: 8'h1D, ext: 1'b0},
    '{code: 8'h1B, ext: 1'b0},
    '{code: 8'h1C, ext: 1'b0},
    '{code: 8'h23, ext: 1'b0},
    '{code: 8'h75, ext: 1'b1},
    '{code: 8'h72, ext: 1'b1},
    '{code: 8'h6B, ext: 1'b1},
    '{code: 8'h74, ext: 1'b1},
    '{code: 8'h29, ext: 1'b0},
    '{code: 8'h76, ext: 1'b0}
  };

  function automatic logic is_overrun(input logic [7:0] b);
    return (b == PS2_OVR_LO) || (b == PS2_OVR_HI);
  endfunction

  function automatic logic is_ignored(input logic [7:0] b);
    return (b == PS2_BAT) || (b == PS2_ACK) ||
           (b == PS2_ECHO) || (b == PS2_RESEND);
  endfunction

endpackage

// File: rtl/ps2_key_lookup.sv
// Combinational scancode + extended flag to game key index.
// Also used by the VGA driver's on-screen help.
module ps2_key_lookup
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  input  logic       ext,
  output logic       hit,
  output logic [3:0] index
);

  always_comb begin
    hit   = 1'b0;
    index = 4'd0;
    for (int i = 0; i < KEY_COUNT; i++) begin
      if (KEY_TABLE[i].code == code &&
          KEY_TABLE[i].ext == ext) begin
        hit   = 1'b1;
        index = 4'(i);
      end
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 make/break decoder: per-key held levels and press pulses,
// with E0/F0 prefix tracking, typematic suppression and prefix timeout.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int NKEYS          = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       kb_data,
  input  logic             kb_valid,
  output logic [NKEYS-1:0] keys_held,
  output logic [NKEYS-1:0] keys_press,
  output logic [7:0]       last_code,
  output logic             last_ext,
  output logic             timeout
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ?
                      $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  ps2_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic do_make;
  logic do_break;
  logic do_clear;
  logic do_upd;
  logic do_tmo;
  logic code_ext;

  logic       key_hit;
  logic [3:0] key_idx;

  logic [NKEYS-1:0] held_nxt;
  logic [NKEYS-1:0] press_nxt;

  assign code_ext = (state == EXT) || (state == EXT_BRK);

  ps2_key_lookup u_lookup (
    .code  (kb_data),
    .ext   (code_ext),
    .hit   (key_hit),
    .index (key_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    do_make   = 1'b0;
    do_break  = 1'b0;
    do_clear  = 1'b0;
    do_upd    = 1'b0;
    do_tmo    = 1'b0;
    if (kb_valid) begin
      cnt_nxt = '0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            (kb_data == PS2_EXT): state_nxt = EXT;
            (kb_data == PS2_BRK): state_nxt = BRK;
            is_overrun(kb_data): begin
              do_clear = 1'b1;
              do_upd   = 1'b1;
            end
            is_ignored(kb_data): ;
            default: begin
              do_make = 1'b1;
              do_upd  = 1'b1;
            end
          endcase
        end
        EXT: begin
          unique case (1'b1)
            (kb_data == PS2_BRK): state_nxt = EXT_BRK;
            (kb_data == PS2_EXT): state_nxt = EXT;
            default: begin
              do_make   = 1'b1;
              do_upd    = 1'b1;
              state_nxt = IDLE;
            end
          endcase
        end
        BRK, EXT_BRK: begin
          unique case (1'b1)
            (kb_data == PS2_BRK): state_nxt = state;
            (kb_data == PS2_EXT): state_nxt = EXT;
            default: begin
              do_break  = 1'b1;
              do_upd    = 1'b1;
              state_nxt = IDLE;
            end
          endcase
        end
        default: state_nxt = IDLE;
      endcase
    end else if (state != IDLE) begin
      // An arriving byte always beats an expiring prefix.
      if (cnt == CNT_LAST) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        do_tmo    = 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  always_comb begin
    held_nxt  = keys_held;
    press_nxt = '0;
    if (do_clear) begin
      held_nxt = '0;
    end
    if (do_make && key_hit && !keys_held[key_idx]) begin
      held_nxt[key_idx]  = 1'b1;
      press_nxt[key_idx] = 1'b1;
    end
    if (do_break && key_hit) begin
      held_nxt[key_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys_held  <= '0;
      keys_press <= '0;
      last_code  <= 8'h00;
      last_ext   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      keys_held  <= held_nxt;
      keys_press <= press_nxt;
      timeout    <= do_tmo;
      if (do_upd) begin
        last_code <= kb_data;
        last_ext  <= code_ext;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: prefix-level reference model checked every
// cycle, directed scenarios with literal expectations, then random bytes.
module tb_ps2_key_tracker;

  localparam int T  = 8;
  localparam int NK = 10;

  logic          clk;
  logic          rst_n;
  logic [7:0]    kb_data;
  logic          kb_valid;
  logic [NK-1:0] keys_held;
  logic [NK-1:0] keys_press;
  logic [7:0]    last_code;
  logic          last_ext;
  logic          timeout;

  int tests = 0;
  int fails = 0;
  bit chk_on = 0;

  ps2_key_tracker #(
    .TIMEOUT_CYCLES (T),
    .NKEYS          (NK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .kb_data    (kb_data),
    .kb_valid   (kb_valid),
    .keys_held  (keys_held),
    .keys_press (keys_press),
    .last_code  (last_code),
    .last_ext   (last_ext),
    .timeout    (timeout)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int key_of(bit [7:0] c, bit e);
    case ({e, c})
      9'h01D: return 0;
      9'h01B: return 1;
      9'h01C: return 2;
      9'h023: return 3;
      9'h175: return 4;
      9'h172: return 5;
      9'h16B: return 6;
      9'h174: return 7;
      9'h029: return 8;
      9'h076: return 9;
      default: return -1;
    endcase
  endfunction

  // Model: which prefixes are pending, plus timestamp of last byte.
  bit          p_ext, p_brk;
  bit [NK-1:0] m_held, m_press;
  bit [7:0]    m_code;
  bit          m_ext, m_tmo;
  longint      cyc = 0;
  longint      last_acc = 0;

  task automatic m_make(bit [7:0] c, bit e);
    int k;
    k = key_of(c, e);
    m_code = c;
    m_ext  = e;
    if (k >= 0 && !m_held[k]) begin
      m_held[k]  = 1;
      m_press[k] = 1;
    end
  endtask

  task automatic m_break(bit [7:0] c, bit e);
    int k;
    k = key_of(c, e);
    m_code = c;
    m_ext  = e;
    if (k >= 0) m_held[k] = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_ext = 0; p_brk = 0;
      m_held = 0; m_press = 0;
      m_code = 0; m_ext = 0; m_tmo = 0;
    end else begin
      m_press = 0;
      m_tmo   = 0;
      if (kb_valid) begin
        last_acc = cyc;
        if (kb_data == 8'hE0) begin
          p_ext = 1; p_brk = 0;
        end else if (kb_data == 8'hF0) begin
          p_brk = 1;
        end else if (!p_ext && !p_brk) begin
          if (kb_data == 8'h00 || kb_data == 8'hFF) begin
            m_held = 0; m_code = kb_data; m_ext = 0;
          end else if (!(kb_data inside {8'hAA, 8'hFA, 8'hEE, 8'hFE})) begin
            m_make(kb_data, 0);
          end
        end else begin
          if (p_brk) m_break(kb_data, p_ext);
          else       m_make(kb_data, 1);
          p_ext = 0; p_brk = 0;
        end
      end else if ((p_ext || p_brk) && (cyc - last_acc == T)) begin
        m_tmo = 1;
        p_ext = 0; p_brk = 0;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("held", 32'(keys_held), 32'(m_held));
      chk("press", 32'(keys_press), 32'(m_press));
      chk("last_code", 32'(last_code), 32'(m_code));
      chk("last_ext", 32'(last_ext), 32'(m_ext));
      chk("timeout", 32'(timeout), 32'(m_tmo));
    end
  end

  task automatic send(bit [7:0] b);
    @(negedge clk);
    kb_valid = 1;
    kb_data  = b;
    @(negedge clk);
    kb_valid = 0;
  endtask

  task automatic send3(bit [7:0] a, bit [7:0] b, bit [7:0] c);
    @(negedge clk); kb_valid = 1; kb_data = a;
    @(negedge clk); kb_data = b;
    @(negedge clk); kb_data = c;
    @(negedge clk); kb_valid = 0;
  endtask

  function automatic bit [7:0] pick_byte();
    bit [7:0] codes [10];
    int r;
    codes = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75,
              8'h72, 8'h6B, 8'h74, 8'h29, 8'h76};
    r = $urandom_range(0, 99);
    if (r < 40) return codes[$urandom_range(0, 9)];
    if (r < 55) return 8'hE0;
    if (r < 70) return 8'hF0;
    if (r < 73) return ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
    if (r < 77) return ($urandom_range(0, 1) != 0) ? 8'hAA : 8'hFE;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    int k;
    rst_n    = 0;
    kb_valid = 0;
    kb_data  = 0;
    repeat (3) @(negedge clk);
    chk("rst_held", 32'(keys_held), 0);
    chk("rst_code", 32'(last_code), 0);
    rst_n  = 1;
    chk_on = 1;

    send(8'h1D);
    chk("w_held", 32'(keys_held), 32'h001);
    chk("w_press", 32'(keys_press), 32'h001);
    chk("w_code", 32'(last_code), 32'h1D);
    @(negedge clk);
    chk("w_press_end", 32'(keys_press), 0);
    send(8'h1D);
    chk("w_repeat", 32'(keys_press), 0);
    send(8'hF0); send(8'h1D);
    chk("w_break", 32'(keys_held), 0);

    send(8'hE0); send(8'h75);
    chk("up_held", 32'(keys_held), 32'h010);
    chk("up_ext", 32'(last_ext), 1);
    send(8'h75);
    chk("kp8_held", 32'(keys_held), 32'h010);
    chk("kp8_ext", 32'(last_ext), 0);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("up_break", 32'(keys_held), 0);

    send(8'hE0); send(8'h75);
    send(8'h1C); send(8'h29);
    send(8'hF0); send(8'h1C);
    chk("multi", 32'(keys_held), 32'h110);

    send(8'hF0);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (timeout) begin k = i; break; end
    end
    chk("tmo_delay", 32'(k), 32'(T));
    send(8'h1D);
    chk("tmo_make", 32'(keys_press), 32'h001);

    send(8'h23); send(8'hE0); send(8'h74);
    chk("pre_ovr", 32'(keys_held), 32'h199);
    send(8'hFF);
    chk("overrun", 32'(keys_held), 0);

    send(8'hE0); send(8'h74);
    send3(8'hE0, 8'hF0, 8'h74);
    chk("b2b", 32'(keys_held), 0);
    send3(8'h1D, 8'h1B, 8'h1C);
    chk("b2b_make", 32'(keys_held), 32'h007);

    send(8'hE0);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_held", 32'(keys_held), 0);
    chk("mid_rst_ext", 32'(last_ext), 0);
    @(negedge clk); #2 rst_n = 1;
    send(8'h75);
    chk("lost_prefix", 32'(keys_held), 0);

    for (int n = 0; n < 1500; n++) begin
      int g;
      if ($urandom_range(0, 199) == 0) begin
        @(negedge clk); #2 rst_n = 0;
        @(negedge clk); #2 rst_n = 1;
      end
      @(negedge clk);
      kb_valid = 1;
      kb_data  = pick_byte();
      g = $urandom_range(0, 9);
      if (g >= 9) g = $urandom_range(6, 12);
      else if (g >= 6) g = g - 5;
      else g = 0;
      for (int j = 0; j < g; j++) begin
        @(negedge clk);
        kb_valid = 0;
      end
    end
    @(negedge clk);
    kb_valid = 0;
    repeat (12) @(negedge clk);
    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
